// File: rtl/sng_pair.sv
// Dual-channel LFSR stochastic number generator: turns two N-bit unsigned operands into a pair
// of unipolar bitstreams, one bit per clock, STREAM_LEN bits per conversion.
module sng_pair #(
  parameter int unsigned    N          = 8,
  parameter logic [N-1:0]   SEED_X     = N'(8'h01),
  parameter logic [N-1:0]   SEED_Y     = N'(8'hA5),
  parameter int unsigned    STREAM_LEN = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] val_x,
  input  logic [N-1:0] val_y,
  output logic         busy,
  output logic         x,
  output logic         y,
  output logic         valid,
  output logic         done
);

  // Maximal-length Fibonacci tap masks; bit (e-1) set for each polynomial term x^e.
  function automatic logic [N-1:0] tap_mask();
    logic [15:0] m;
    case (N)
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0E08;
      13:      m = 16'h1C80;
      14:      m = 16'h3802;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h00B8;
    endcase
    return m[N-1:0];
  endfunction

  localparam logic [N-1:0] Taps    = tap_mask();
  localparam logic [N-1:0] CntLast = N'(STREAM_LEN - 1);

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] v);
    return {v[N-2:0], ^(v & Taps)};
  endfunction

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < int'(N); i++) begin
      r[i] = v[N-1-i];
    end
    return r;
  endfunction

  typedef enum logic {StIdle, StRun} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] vx_q, vx_d;
  logic [N-1:0] vy_q, vy_d;
  logic [N-1:0] lfsr_x_q, lfsr_x_d;
  logic [N-1:0] lfsr_y_q, lfsr_y_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         x_q, x_d;
  logic         y_q, y_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic bx, by;

  // Y compares against the bit-reversed state so the two channels are decorrelated.
  assign bx = (lfsr_x_q <= vx_q);
  assign by = (bitrev(lfsr_y_q) <= vy_q);

  always_comb begin
    state_d  = state_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    lfsr_x_d = lfsr_x_q;
    lfsr_y_d = lfsr_y_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    x_d      = 1'b0;
    y_d      = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          vx_d     = val_x;
          vy_d     = val_y;
          lfsr_x_d = SEED_X;
          lfsr_y_d = SEED_Y;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        x_d      = bx;
        y_d      = by;
        valid_d  = 1'b1;
        lfsr_x_d = lfsr_step(lfsr_x_q);
        lfsr_y_d = lfsr_step(lfsr_y_q);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      vx_q     <= '0;
      vy_q     <= '0;
      lfsr_x_q <= SEED_X;
      lfsr_y_q <= SEED_Y;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      lfsr_x_q <= lfsr_x_d;
      lfsr_y_q <= lfsr_y_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign x     = x_q;
  assign y     = y_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sng_pair.sv
// Bench for sng_pair: a schedule-based model (accept edge + bit index into precomputed LFSR
// orbits) checked every cycle, plus directed conversions with hand-computed popcounts.
module tb_sng_pair;

  localparam int L = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] val_x = '0;
  logic [7:0] val_y = '0;
  logic       busy, x, y, valid, done;

  logic       start16 = 1'b0;
  logic [7:0] vx16 = '0;
  logic [7:0] vy16 = '0;
  logic       busy16, x16, y16, valid16, done16;

  sng_pair dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .val_x (val_x),
    .val_y (val_y),
    .busy  (busy),
    .x     (x),
    .y     (y),
    .valid (valid),
    .done  (done)
  );

  sng_pair #(.N(8), .STREAM_LEN(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .val_x (vx16),
    .val_y (vy16),
    .busy  (busy16),
    .x     (x16),
    .y     (y16),
    .valid (valid16),
    .done  (done16)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // LFSR orbits from the seeds under x^8+x^6+x^5+x^4+1.
  logic [7:0] seqx [0:L-1];
  logic [7:0] seqy [0:L-1];

  // Model: a conversion accepted at edge acc emits bit (t-acc-1) after edge t, for t-acc in 1..L.
  int         edge_n = 0;
  int         acc = 0;
  bit         have = 1'b0;
  bit         m_busy = 1'b0;
  logic [7:0] m_vx = '0;
  logic [7:0] m_vy = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have   = 1'b0;
      m_busy = 1'b0;
    end else begin
      edge_n++;
      if (!m_busy && start) begin
        acc  = edge_n;
        have = 1'b1;
        m_vx = val_x;
        m_vy = val_y;
      end
      m_busy = have && ((edge_n - acc) < L);
    end
  end

  int exp_ox = 0;
  int exp_oy = 0;
  int nv = 0;
  int ox = 0;
  int oy = 0;

  always @(negedge clk) begin
    int   rel;
    logic ev, ex, ey, ed;
    rel = edge_n - acc;
    ev  = rst_n && have && rel >= 1 && rel <= L;
    ex  = 1'b0;
    ey  = 1'b0;
    if (ev) begin
      ex = (seqx[rel-1] <= m_vx);
      ey = (rev8(seqy[rel-1]) <= m_vy);
    end
    ed = ev && (rel == L);
    chk1("valid", valid, ev);
    chk1("x", x, ex);
    chk1("y", y, ey);
    chk1("done", done, ed);
    chk1("busy", busy, rst_n && m_busy);
    if (!rst_n) begin
      nv = 0;
      ox = 0;
      oy = 0;
    end else begin
      if (valid === 1'b1) begin
        nv++;
        ox += int'(x);
        oy += int'(y);
      end
      if (done === 1'b1) begin
        chk("ones_x", ox, exp_ox);
        chk("ones_y", oy, exp_oy);
        chk("stream_len", nv, L);
        nv = 0;
        ox = 0;
        oy = 0;
      end
    end
  end

  task automatic start_conv(input logic [7:0] vx, input logic [7:0] vy, input int ex,
                            input int ey);
    @(negedge clk);
    val_x  = vx;
    val_y  = vy;
    exp_ox = ex;
    exp_oy = ey;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_done(input int bound, output int busy_n);
    bit seen = 1'b0;
    busy_n = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] l;
    bit         seen_v [0:255];
    int         distinct, le128, bn, nd, done_at;

    l = 8'h01;
    for (int i = 0; i < L; i++) begin
      seqx[i] = l;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    l = 8'hA5;
    for (int i = 0; i < L; i++) begin
      seqy[i] = l;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    for (int i = 0; i < 256; i++) seen_v[i] = 1'b0;
    distinct = 0;
    le128 = 0;
    for (int i = 0; i < L; i++) begin
      if (!seen_v[seqx[i]] && seqx[i] != 0) distinct++;
      seen_v[seqx[i]] = 1'b1;
      if (seqx[i] <= 8'd128) le128++;
    end
    chk("model_period", distinct, 255);
    chk("model_le128", le128, 128);

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_x", x, 1'b0);
    chk1("rst16_busy", busy16, 1'b0);
    #2 rst_n = 1'b1;

    // Extremes: all-zero X stream, all-one Y stream.
    start_conv(8'd0, 8'd255, 0, 255);
    wait_done(400, bn);
    chk("busy_cycles", bn + 1, 255);
    chk1("busy_in_done_cycle", busy, 1'b0);
    @(negedge clk);
    chk1("idle_valid", valid, 1'b0);

    // Mid values; first bits come from the seeds.
    start_conv(8'd128, 8'd64, 128, 64);
    @(negedge clk);
    chk1("first_valid", valid, 1'b1);
    chk1("first_x", x, 1'b1);
    chk1("first_y", y, 1'b0);
    wait_done(400, bn);

    // Start held high: accepted again right after the done cycle.
    @(negedge clk);
    val_x  = 8'd200;
    val_y  = 8'd200;
    exp_ox = 200;
    exp_oy = 200;
    start  = 1'b1;
    wait_done(400, bn);
    @(negedge clk);
    chk1("rearm_busy", busy, 1'b1);
    wait_done(400, bn);
    start = 1'b0;
    @(negedge clk);
    chk1("stop_busy", busy, 1'b0);

    // Starts during RUN are ignored; operand changes have no effect.
    start_conv(8'd50, 8'd10, 50, 10);
    repeat (8) @(negedge clk);
    val_x = 8'd222;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (89) @(negedge clk);
    val_y = 8'd250;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400, bn);

    // Reset mid-run abandons the conversion.
    start_conv(8'd99, 8'd99, 99, 99);
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_valid", valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_x", x, 1'b0);
    chk1("abort_y", y, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    start_conv(8'd17, 8'd3, 17, 3);
    wait_done(400, bn);

    // Short stream on the STREAM_LEN=16 instance.
    @(negedge clk);
    vx16    = 8'd255;
    vy16    = 8'd0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    nd = 0;
    done_at = 0;
    begin
      int sv, sx, sy;
      sv = 0;
      sx = 0;
      sy = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (valid16) begin
          sv++;
          sx += int'(x16);
          sy += int'(y16);
        end
        if (done16) begin
          nd++;
          done_at = sv;
          chk1("short_busy_at_done", busy16, 1'b0);
        end
      end
      chk("short_valid", sv, 16);
      chk("short_ones_x", sx, 16);
      chk("short_ones_y", sy, 0);
    end
    chk("short_done_count", nd, 1);
    chk("short_done_at", done_at, 16);
    chk1("short_busy_after", busy16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
